// File: rtl/data_memory_ctrl.sv
// Data memory controller for the MIPS load/store path.
// Byte/half/word accesses with little-endian lanes, sign/zero-extended loads,
// req/done handshake with a configurable number of wait states, and error
// reporting for misaligned, out-of-range and reserved-size accesses.
module data_memory_ctrl #(
  parameter int DEPTH          = 256,
  parameter int WAIT_CYCLES    = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        signExt,
  input  logic [31:0] address,
  input  logic [31:0] wrData,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] readData
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;

  // Request fields captured at accept
  logic            l_we;
  logic [1:0]      l_size;
  logic            l_sx;
  logic [AW+1:0]   l_addr;
  logic [31:0]     l_wd;

  // Effective access fields: live inputs on the accept edge, latched ones later
  logic            a_we;
  logic [1:0]      a_size;
  logic            a_sx;
  logic [AW+1:0]   a_addr;
  logic [31:0]     a_wd;

  logic            err_now;
  logic            access;
  logic            wr_en;
  logic [AW-1:0]   idx;
  logic [4:0]      lane_sh;
  logic [31:0]     word_q;
  logic [31:0]     lane_mask;
  logic [31:0]     wr_shift;
  logic [31:0]     merged;
  logic [31:0]     rd_shift;
  logic [31:0]     load_val;

  logic [31:0]     mem [DEPTH];

  // Access decode: error check, lane selection, store merge and load extension
  always_comb begin
    a_we    = l_we;
    a_size  = l_size;
    a_sx    = l_sx;
    a_addr  = l_addr;
    a_wd    = l_wd;
    if (state == S_IDLE) begin
      a_we    = we;
      a_size  = size;
      a_sx    = signExt;
      a_addr  = address[AW+1:0];
      a_wd    = wrData;
    end

    err_now = (size == 2'b11) ||
              ((size == 2'b01) && address[0]) ||
              ((size == 2'b10) && (address[1:0] != 2'b00)) ||
              (address[31:AW+2] != '0);

    // Zero-wait accesses happen on the accept edge itself; otherwise at the
    // last WAIT edge using the latched request.
    access = ((state == S_IDLE) && req && !err_now && (WAIT_CYCLES == 0)) ||
             ((state == S_WAIT) && (cnt == '0));
    wr_en  = access && a_we && resetN;

    idx     = a_addr[AW+1:2];
    lane_sh = {a_addr[1:0], 3'b000};
    word_q  = mem[idx];

    unique case (a_size)
      2'b00:   lane_mask = 32'h0000_00FF << lane_sh;
      2'b01:   lane_mask = 32'h0000_FFFF << lane_sh;
      default: lane_mask = '1;
    endcase
    wr_shift = a_wd << lane_sh;
    merged   = (word_q & ~lane_mask) | (wr_shift & lane_mask);

    rd_shift = word_q >> lane_sh;
    unique case (a_size)
      2'b00:   load_val = a_sx ? {{24{rd_shift[7]}}, rd_shift[7:0]}
                               : {24'h0, rd_shift[7:0]};
      2'b01:   load_val = a_sx ? {{16{rd_shift[15]}}, rd_shift[15:0]}
                               : {16'h0, rd_shift[15:0]};
      default: load_val = word_q;
    endcase
  end

  // Handshake FSM with registered busy/done/err and load result
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= S_IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      readData <= '0;
      l_we     <= 1'b0;
      l_size   <= '0;
      l_sx     <= 1'b0;
      l_addr   <= '0;
      l_wd     <= '0;
    end else begin
      if (access && !a_we) begin
        readData <= load_val;
      end
      unique case (state)
        S_IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (req) begin
            l_we   <= we;
            l_size <= size;
            l_sx   <= signExt;
            l_addr <= address[AW+1:0];
            l_wd   <= wrData;
            busy   <= 1'b1;
            if (err_now) begin
              state <= S_RESP;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (WAIT_CYCLES == 0) begin
              state <= S_RESP;
              done  <= 1'b1;
            end else begin
              state <= S_WAIT;
              cnt   <= CW'(WAIT_CYCLES - 1);
            end
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            state <= S_RESP;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
        end
      endcase
    end
  end

  generate
    if (CLEAR_ON_RESET != 0) begin : g_clr
      // Word array, cleared asynchronously by reset
      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          for (int unsigned i = 0; i < unsigned'(DEPTH); i++) begin
            mem[i] <= '0;
          end
        end else if (wr_en) begin
          mem[idx] <= merged;
        end
      end
    end else begin : g_keep
      // Word array, contents retained through reset
      always_ff @(posedge clk) begin
        if (wr_en) begin
          mem[idx] <= merged;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl: three instances (0, 1 and 3 wait
// states; the last one retains contents through reset) against a byte-array
// reference model.
module tb_data_memory_ctrl;

  localparam int DEPTH = 256;
  localparam int NB    = DEPTH * 4;

  logic        clk = 1'b0;
  logic        resetN;
  logic [2:0]  req_v;
  logic        we;
  logic [1:0]  size;
  logic        sx;
  logic [31:0] address;
  logic [31:0] wrData;
  logic [2:0]  busy_v, done_v, err_v;
  logic [31:0] rd0, rd1, rd2;

  always #5 clk = ~clk;

  data_memory_ctrl #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .CLEAR_ON_RESET(1)) u0 (
    .clk(clk), .resetN(resetN), .req(req_v[0]), .we(we), .size(size),
    .signExt(sx), .address(address), .wrData(wrData),
    .busy(busy_v[0]), .done(done_v[0]), .err(err_v[0]), .readData(rd0));

  data_memory_ctrl #(.DEPTH(DEPTH), .WAIT_CYCLES(1), .CLEAR_ON_RESET(1)) u1 (
    .clk(clk), .resetN(resetN), .req(req_v[1]), .we(we), .size(size),
    .signExt(sx), .address(address), .wrData(wrData),
    .busy(busy_v[1]), .done(done_v[1]), .err(err_v[1]), .readData(rd1));

  data_memory_ctrl #(.DEPTH(DEPTH), .WAIT_CYCLES(3), .CLEAR_ON_RESET(0)) u2 (
    .clk(clk), .resetN(resetN), .req(req_v[2]), .we(we), .size(size),
    .signExt(sx), .address(address), .wrData(wrData),
    .busy(busy_v[2]), .done(done_v[2]), .err(err_v[2]), .readData(rd2));

  int waits [3] = '{0, 1, 3};
  bit clrs  [3] = '{1'b1, 1'b1, 1'b0};

  logic [7:0]  mm  [3][NB];
  logic [31:0] mrd [3];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          dut;
    bit          w;
    logic [1:0]  sz;
    bit          s;
    logic [31:0] a;
    logic [31:0] wd;
    bit          eerr;
    logic [31:0] erd;
  } vec_t;

  vec_t tbl [24];

  function automatic vec_t mk(int d, bit w, logic [1:0] sz, bit s,
                              logic [31:0] a, logic [31:0] wd,
                              bit eerr, logic [31:0] erd);
    vec_t v;
    v.dut = d; v.w = w; v.sz = sz; v.s = s; v.a = a; v.wd = wd;
    v.eerr = eerr; v.erd = erd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_of(int d);
    case (d)
      0:       return rd0;
      1:       return rd1;
      default: return rd2;
    endcase
  endfunction

  // Reference: byte-addressed memory, plain little-endian assembly
  task automatic model_op(input int d, input bit w, input logic [1:0] sz, input bit s,
                          input logic [31:0] a, input logic [31:0] wd, output bit e);
    int n;
    logic [31:0] v;
    e = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) ||
        (a >= 32'(NB));
    if (e) return;
    n = 1 << sz;
    if (w) begin
      for (int i = 0; i < n; i++) mm[d][a + 32'(i)] = wd[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v = v | (32'(mm[d][a + 32'(i)]) << (8*i));
      if (s && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      mrd[d] = v;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      mrd[d] = '0;
      if (clrs[d]) for (int i = 0; i < NB; i++) mm[d][i] = 8'h00;
    end
  endtask

  // One transaction: drive, check latency/err/readData, check the done pulse ends
  task automatic run_op(input int d, input bit w, input logic [1:0] sz, input bit s,
                        input logic [31:0] a, input logic [31:0] wd, input bit hold,
                        output bit gerr, output logic [31:0] grd);
    bit eerr;
    int lat;
    model_op(d, w, sz, s, a, wd, eerr);
    @(negedge clk);
    we = w; size = sz; sx = s; address = a; wrData = wd; req_v[d] = 1'b1;
    @(posedge clk);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        we = 1'($urandom); size = 2'($urandom); sx = 1'($urandom);
        address = $urandom; wrData = $urandom;
      end
      if (!hold) req_v[d] = 1'b0;
      if (done_v[d]) begin
        lat = c;
        break;
      end
    end
    chk($sformatf("latency d%0d a=%h", d, a), lat, eerr ? 1 : waits[d] + 1);
    gerr = err_v[d];
    grd  = rd_of(d);
    chk($sformatf("err d%0d a=%h", d, a), gerr, eerr);
    chk($sformatf("readData d%0d a=%h", d, a), grd, mrd[d]);
    if (hold) begin
      @(posedge clk);
      #1 req_v[d] = 1'b0;
    end
    @(negedge clk);
    chk($sformatf("idle_after d%0d", d), {done_v[d], busy_v[d]}, 0);
  endtask

  // Hold req high for several back-to-back periods and count completions
  task automatic cont_req(input int d);
    bit e;
    int n, dones;
    n = 4 * (waits[d] + 2);
    model_op(d, 1'b0, 2'd2, 1'b0, 32'h10, '0, e);
    @(negedge clk);
    we = 1'b0; size = 2'd2; sx = 1'b0; address = 32'h10; wrData = '0;
    req_v[d] = 1'b1;
    dones = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_v[d]) dones++;
    end
    req_v[d] = 1'b0;
    chk($sformatf("cont_dones d%0d", d), dones, 4);
    chk($sformatf("cont_readData d%0d", d), rd_of(d), mrd[d]);
    @(negedge clk);
    chk($sformatf("cont_idle d%0d", d), {done_v[d], busy_v[d]}, 0);
  endtask

  // Reset asserted while the store sits in WAIT; the store must be dropped
  task automatic reset_abort(input int d);
    bit ge;
    logic [31:0] gr;
    logic [31:0] prior;
    prior = 32'h1111_1111 + 32'(d);
    run_op(d, 1'b1, 2'd2, 1'b0, 32'h20, prior, 1'b0, ge, gr);
    @(negedge clk);
    we = 1'b1; size = 2'd2; sx = 1'b0; address = 32'h20; wrData = 32'hCAFE_F00D;
    req_v[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_v[d] = 1'b0;
    chk($sformatf("abort_busy d%0d", d), busy_v[d], 1);
    resetN = 1'b0;
    #1;
    chk($sformatf("abort_flags d%0d", d), {busy_v[d], done_v[d], err_v[d]}, 0);
    chk($sformatf("abort_rd d%0d", d), rd_of(d), 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
    run_op(d, 1'b0, 2'd2, 1'b0, 32'h20, '0, 1'b0, ge, gr);
    chk($sformatf("abort_readback d%0d", d), gr, clrs[d] ? 32'h0 : prior);
  endtask

  initial begin
    bit ge;
    logic [31:0] gr;
    logic [1:0] rsz;
    logic [31:0] ra;
    int r;

    resetN = 1'b0; req_v = '0; we = 1'b0; size = '0; sx = 1'b0;
    address = '0; wrData = '0;
    for (int d = 0; d < 3; d++) begin
      mrd[d] = '0;
      for (int i = 0; i < NB; i++) mm[d][i] = 8'h00;
    end

    tbl[0]  = mk(1, 1, 2, 0, 32'h10,  32'hDEAD_BEEF, 0, 32'h0000_0000);
    tbl[1]  = mk(1, 0, 2, 0, 32'h10,  32'h0,         0, 32'hDEAD_BEEF);
    tbl[2]  = mk(1, 1, 0, 0, 32'h11,  32'hA5A5_A580, 0, 32'hDEAD_BEEF);
    tbl[3]  = mk(1, 0, 0, 1, 32'h11,  32'h0,         0, 32'hFFFF_FF80);
    tbl[4]  = mk(1, 0, 0, 0, 32'h11,  32'h0,         0, 32'h0000_0080);
    tbl[5]  = mk(1, 0, 2, 0, 32'h10,  32'h0,         0, 32'hDEAD_80EF);
    tbl[6]  = mk(1, 1, 1, 0, 32'h12,  32'h5A5A_1234, 0, 32'hDEAD_80EF);
    tbl[7]  = mk(1, 0, 2, 0, 32'h10,  32'h0,         0, 32'h1234_80EF);
    tbl[8]  = mk(1, 0, 1, 1, 32'h12,  32'h0,         0, 32'h0000_1234);
    tbl[9]  = mk(1, 0, 1, 0, 32'h13,  32'h0,         1, 32'h0000_1234);
    tbl[10] = mk(1, 1, 2, 0, 32'h0A,  32'h7777_7777, 1, 32'h0000_1234);
    tbl[11] = mk(1, 0, 3, 0, 32'h10,  32'h0,         1, 32'h0000_1234);
    tbl[12] = mk(1, 1, 2, 0, 32'h400, 32'hFFFF_FFFF, 1, 32'h0000_1234);
    tbl[13] = mk(1, 0, 2, 0, 32'h10,  32'h0,         0, 32'h1234_80EF);
    tbl[14] = mk(1, 0, 0, 1, 32'h13,  32'h0,         0, 32'h0000_0012);
    tbl[15] = mk(1, 0, 1, 1, 32'h10,  32'h0,         0, 32'hFFFF_80EF);
    tbl[16] = mk(1, 0, 1, 0, 32'h10,  32'h0,         0, 32'h0000_80EF);
    tbl[17] = mk(1, 1, 2, 0, 32'h3FC, 32'h89AB_CDEF, 0, 32'h0000_80EF);
    tbl[18] = mk(1, 0, 0, 1, 32'h3FF, 32'h0,         0, 32'hFFFF_FF89);
    tbl[19] = mk(1, 0, 2, 0, 32'h3FC, 32'h0,         0, 32'h89AB_CDEF);
    tbl[20] = mk(1, 0, 2, 0, 32'h400, 32'h0,         1, 32'h89AB_CDEF);
    tbl[21] = mk(1, 0, 0, 0, 32'h3FE, 32'h0,         0, 32'h0000_00AB);
    tbl[22] = mk(1, 0, 2, 0, 32'h00,  32'h0,         0, 32'h0000_0000);
    tbl[23] = mk(1, 0, 2, 0, 32'h08,  32'h0,         0, 32'h0000_0000);

    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_flags d%0d", d), {busy_v[d], done_v[d], err_v[d]}, 0);
      chk($sformatf("reset_rd d%0d", d), rd_of(d), 0);
    end
    resetN = 1'b1;

    // The retaining instance starts with undefined contents: fill it first
    for (int w = 0; w < DEPTH; w++)
      run_op(2, 1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, 1'b0, ge, gr);

    for (int i = 0; i < 24; i++) begin
      run_op(tbl[i].dut, tbl[i].w, tbl[i].sz, tbl[i].s, tbl[i].a, tbl[i].wd, 1'b0, ge, gr);
      chk($sformatf("tbl%0d err", i), ge, tbl[i].eerr);
      chk($sformatf("tbl%0d readData", i), gr, tbl[i].erd);
    end

    // Latency on the other wait-state settings, and req held through an access
    run_op(0, 1'b1, 2'd2, 1'b0, 32'h44, 32'h0BAD_F00D, 1'b0, ge, gr);
    run_op(0, 1'b0, 2'd2, 1'b0, 32'h44, '0, 1'b0, ge, gr);
    chk("w0_readback", gr, 32'h0BAD_F00D);
    run_op(2, 1'b1, 2'd1, 1'b0, 32'h46, 32'h0000_C001, 1'b0, ge, gr);
    run_op(2, 1'b0, 2'd1, 1'b1, 32'h46, '0, 1'b0, ge, gr);
    chk("w3_readback", gr, 32'hFFFF_C001);
    for (int d = 0; d < 3; d++) run_op(d, 1'b0, 2'd2, 1'b0, 32'h10, '0, 1'b1, ge, gr);
    for (int d = 0; d < 3; d++) cont_req(d);

    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 150; k++) begin
        r   = int'($urandom_range(0, 9));
        rsz = 2'($urandom);
        if (r == 0) ra = $urandom;
        else ra = 32'($urandom_range(0, NB - 1));
        if (r < 7 && rsz != 2'd3) ra = ra & ~((32'd1 << rsz) - 32'd1);
        run_op(d, 1'($urandom), rsz, 1'($urandom), ra, $urandom, 1'b0, ge, gr);
      end
    end

    reset_abort(1);
    reset_abort(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
